uart_tx_word_serializer: RTL and testbench

//  Transmit-side buffer between the pipeline debug interface and the UART TX core.

---
 rtl/uart_tx_word_serializer_if.sv | 22 ++
 rtl/uart_tx_word_serializer.sv | 113 +++++++++++
 tb/tb_uart_tx_word_serializer.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_word_serializer_if.sv
// Word-push / byte-handshake bundle between the debug interface, the serializer and the UART
// TX core.
interface uart_tx_word_serializer_if;
  logic [31:0] i_word;
  logic        i_word_valid;
  logic        i_tx_done;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        o_word_ready;
  logic        o_busy;
  logic        o_overflow;

  modport master (
    output i_word, i_word_valid, i_tx_done,
    input  o_tx_data, o_tx_start, o_word_ready, o_busy, o_overflow
  );

  modport slave (
    input  i_word, i_word_valid, i_tx_done,
    output o_tx_data, o_tx_start, o_word_ready, o_busy, o_overflow
  );
endinterface

// File: rtl/uart_tx_word_serializer.sv
// Buffers 32-bit debug words in a small FIFO and feeds them to a UART TX core one byte per
// start/done handshake.
module uart_tx_word_serializer #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned FIFO_ADDR_BITS = 2,
  parameter bit          MSB_FIRST      = 1'b0
) (
  input logic                      i_clk,
  input logic                      i_reset,
  uart_tx_word_serializer_if.slave bus
);

  localparam int unsigned Depth = 1 << FIFO_ADDR_BITS;
  localparam int unsigned CntW  = FIFO_ADDR_BITS + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);
  localparam logic [CntW-1:0] CntTwo = CntW'(2);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StSend     = 2'd1;
  localparam logic [1:0] StWaitDone = 2'd2;

  logic [WORD_WIDTH-1:0]     mem_q [Depth];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]           count_q;
  logic [1:0]                state_q;
  logic [1:0]                byte_cnt_q;
  logic [WORD_WIDTH-1:0]     word_q;
  logic [7:0]                tx_data_q;
  logic                      tx_start_q;
  logic                      overflow_q;

  logic                  has_word, full, pop, push;
  logic [WORD_WIDTH-1:0] head;

  function automatic logic [7:0] sel_byte(input logic [WORD_WIDTH-1:0] w, input logic [1:0] k);
    logic [1:0] idx;
    idx = MSB_FIRST ? ~k : k;
    return w[{idx, 3'b000} +: 8];
  endfunction

  assign has_word = (count_q != '0);
  assign full     = (count_q == DepthC);
  assign head     = mem_q[rd_ptr_q];
  // A word leaves the FIFO either from idle or right after the last byte of the previous word.
  assign pop  = has_word &&
                ((state_q == StIdle) ||
                 ((state_q == StWaitDone) && bus.i_tx_done && (byte_cnt_q == 2'd3)));
  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  assign push = bus.i_word_valid && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_word;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_ADDR_BITS'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_ADDR_BITS'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
      if (bus.i_word_valid && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      byte_cnt_q <= 2'd0;
      word_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else if (pop) begin
      word_q     <= head;
      byte_cnt_q <= 2'd0;
      tx_data_q  <= sel_byte(head, 2'd0);
      tx_start_q <= 1'b1;
      state_q    <= StSend;
    end else begin
      case (state_q)
        StSend: begin
          tx_start_q <= 1'b0;
          state_q    <= StWaitDone;
        end
        StWaitDone: begin
          if (bus.i_tx_done) begin
            if (byte_cnt_q != 2'd3) begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              tx_data_q  <= sel_byte(word_q, byte_cnt_q + 2'd1);
              tx_start_q <= 1'b1;
              state_q    <= StSend;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StIdle: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_word_ready = ((DepthC - count_q) >= CntTwo);
  assign bus.o_busy       = (state_q != StIdle) || has_word;
  assign bus.o_overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// Bench for uart_tx_word_serializer: byte scoreboard per instance, UART core responder models.
module tb_uart_tx_word_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_word_serializer_if ifa ();
  uart_tx_word_serializer_if ifb ();

  uart_tx_word_serializer #(
    .WORD_WIDTH(32), .FIFO_ADDR_BITS(2), .MSB_FIRST(1'b0)
  ) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(ifa.slave)
  );

  uart_tx_word_serializer #(
    .WORD_WIDTH(32), .FIFO_ADDR_BITS(2), .MSB_FIRST(1'b1)
  ) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(ifb.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int starts_a = 0;
  int starts_b = 0;
  bit auto_a = 1'b0;
  bit auto_b = 1'b0;
  int gap = 10;
  int cnt_a = 0;
  int cnt_b = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic prev_start_a = 1'b0;
  logic prev_start_b = 1'b0;

  initial begin
    ifa.i_word = '0; ifa.i_word_valid = 1'b0; ifa.i_tx_done = 1'b0;
    ifb.i_word = '0; ifb.i_word_valid = 1'b0; ifb.i_tx_done = 1'b0;
  end

  // Scoreboard: each start pulse must be one cycle wide and carry the next expected byte.
  always @(negedge clk) begin
    if (ifa.o_tx_start) begin
      starts_a++;
      n_tests++;
      if (prev_start_a) begin
        n_fail++;
        $display("FAIL start_width_a: start high 2 cycles, need 1 cycle");
      end else if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte_a: got %02h, need no start", ifa.o_tx_data);
      end else begin
        logic [7:0] exp_a;
        exp_a = q_a.pop_front();
        if (ifa.o_tx_data !== exp_a) begin
          n_fail++;
          $display("FAIL byte_a: got %02h, need %02h", ifa.o_tx_data, exp_a);
        end
      end
    end
    prev_start_a = ifa.o_tx_start;
  end

  always @(negedge clk) begin
    if (ifb.o_tx_start) begin
      starts_b++;
      n_tests++;
      if (prev_start_b) begin
        n_fail++;
        $display("FAIL start_width_b: start high 2 cycles, need 1 cycle");
      end else if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte_b: got %02h, need no start", ifb.o_tx_data);
      end else begin
        logic [7:0] exp_b;
        exp_b = q_b.pop_front();
        if (ifb.o_tx_data !== exp_b) begin
          n_fail++;
          $display("FAIL byte_b: got %02h, need %02h", ifb.o_tx_data, exp_b);
        end
      end
    end
    prev_start_b = ifb.o_tx_start;
  end

  // UART core models: raise done for one cycle, gap cycles after each start.
  initial forever begin
    @(negedge clk);
    if (auto_a) begin
      if (ifa.i_tx_done) ifa.i_tx_done = 1'b0;
      if (ifa.o_tx_start) cnt_a = gap;
      else if (cnt_a == 1) begin ifa.i_tx_done = 1'b1; cnt_a = 0; end
      else if (cnt_a > 1) cnt_a--;
    end
  end

  initial forever begin
    @(negedge clk);
    if (auto_b) begin
      if (ifb.i_tx_done) ifb.i_tx_done = 1'b0;
      if (ifb.o_tx_start) cnt_b = gap;
      else if (cnt_b == 1) begin ifb.i_tx_done = 1'b1; cnt_b = 0; end
      else if (cnt_b > 1) cnt_b--;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] w, input bit accept);
    if (accept) for (int k = 0; k < 4; k++) q_a.push_back(w[8*k +: 8]);
    ifa.i_word = w;
    ifa.i_word_valid = 1'b1;
    tick();
    ifa.i_word_valid = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] w);
    for (int k = 0; k < 4; k++) q_b.push_back(w[8*(3-k) +: 8]);
    ifb.i_word = w;
    ifb.i_word_valid = 1'b1;
    tick();
    ifb.i_word_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    auto_a = 1'b0; auto_b = 1'b0;
    cnt_a = 0; cnt_b = 0;
    ifa.i_tx_done = 1'b0; ifa.i_word_valid = 1'b0;
    ifb.i_tx_done = 1'b0; ifb.i_word_valid = 1'b0;
    q_a.delete(); q_b.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input int limit, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (q_a.size() == 0 && q_b.size() == 0 && !ifa.o_busy && !ifb.o_busy) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d/%0d bytes pending, need 0 and idle within %0d cycles",
               name, q_a.size(), q_b.size(), limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if ({ifa.o_tx_data, ifa.o_tx_start, ifa.o_word_ready, ifa.o_busy, ifa.o_overflow}
        !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_a: got data=%02h start=%b ready=%b busy=%b ovf=%b, need 00 0 1 0 0",
               ifa.o_tx_data, ifa.o_tx_start, ifa.o_word_ready, ifa.o_busy, ifa.o_overflow);
    end
    n_tests++;
    if ({ifb.o_tx_data, ifb.o_tx_start, ifb.o_word_ready, ifb.o_busy, ifb.o_overflow}
        !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_b: got data=%02h start=%b ready=%b busy=%b ovf=%b, need 00 0 1 0 0",
               ifb.o_tx_data, ifb.o_tx_start, ifb.o_word_ready, ifb.o_busy, ifb.o_overflow);
    end
    do_reset();
  endtask

  task automatic test_lsb_first();
    int base;
    do_reset();
    gap = 10; auto_a = 1'b1;
    base = starts_a;
    push_a(32'h44434241, 1'b1);
    n_tests++;
    if (ifa.o_tx_start !== 1'b0 || ifa.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_capture: got start=%b busy=%b, need 0 1", ifa.o_tx_start, ifa.o_busy);
    end
    tick();
    n_tests++;
    if (ifa.o_tx_start !== 1'b1 || ifa.o_tx_data !== 8'h41) begin
      n_fail++;
      $display("FAIL latency_first_byte: got start=%b data=%02h, need 1 41",
               ifa.o_tx_start, ifa.o_tx_data);
    end
    wait_drain(200, "lsb_first");
    n_tests++;
    if (starts_a - base != 4 || ifa.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_first_count: got %0d starts busy=%b, need 4 starts busy=0",
               starts_a - base, ifa.o_busy);
    end
  endtask

  task automatic test_msb_first();
    int base;
    do_reset();
    gap = 4; auto_b = 1'b1;
    base = starts_b;
    push_b(32'h11223344);
    wait_drain(200, "msb_first");
    n_tests++;
    if (starts_b - base != 4) begin
      n_fail++;
      $display("FAIL msb_first_count: got %0d starts, need 4", starts_b - base);
    end
  endtask

  task automatic test_overflow();
    int base;
    logic [4:0] exp_ready;
    logic [4:0] exp_ovf;
    exp_ready = 5'b00011;
    exp_ovf   = 5'b10000;
    do_reset();
    base = starts_a;
    push_a(32'h5555AAAA, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      push_a(32'hA0A0A0A0 + 32'(k), k < 4);
      n_tests++;
      if (ifa.o_word_ready !== exp_ready[k] || ifa.o_overflow !== exp_ovf[k]) begin
        n_fail++;
        $display("FAIL fill_push%0d: got ready=%b ovf=%b, need ready=%b ovf=%b",
                 k, ifa.o_word_ready, ifa.o_overflow, exp_ready[k], exp_ovf[k]);
      end
    end
    gap = 2; cnt_a = 1; auto_a = 1'b1;
    wait_drain(400, "overflow");
    n_tests++;
    if (starts_a - base != 20 || ifa.o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_drain: got %0d starts ovf=%b, need 20 starts ovf=1",
               starts_a - base, ifa.o_overflow);
    end
  endtask

  task automatic test_full_push_pop();
    int base;
    do_reset();
    base = starts_a;
    push_a(32'h03020100, 1'b1);
    for (int k = 1; k <= 4; k++) push_a(32'h10000000 * k + 32'h00C0B0A0, 1'b1);
    n_tests++;
    if (ifa.o_word_ready !== 1'b0 || ifa.o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_setup: got ready=%b ovf=%b, need 0 0", ifa.o_word_ready, ifa.o_overflow);
    end
    for (int b = 0; b < 4; b++) begin
      tick();
      ifa.i_tx_done = 1'b1;
      if (b == 3) push_a(32'h77665544, 1'b1);
      else tick();
      ifa.i_tx_done = 1'b0;
    end
    n_tests++;
    if (ifa.o_tx_start !== 1'b1 || ifa.o_overflow !== 1'b0 || ifa.o_word_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop: got start=%b ovf=%b ready=%b, need 1 0 0",
               ifa.o_tx_start, ifa.o_overflow, ifa.o_word_ready);
    end
    gap = 3; auto_a = 1'b1; cnt_a = gap;
    wait_drain(600, "full_push_pop");
    n_tests++;
    if (starts_a - base != 24 || ifa.o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop_count: got %0d starts ovf=%b, need 24 ovf=0",
               starts_a - base, ifa.o_overflow);
    end
  endtask

  task automatic test_reset_mid_word();
    int base;
    bit seen;
    do_reset();
    gap = 5; auto_a = 1'b1;
    base = starts_a;
    seen = 1'b0;
    push_a(32'hDEADBEEF, 1'b1);
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (starts_a - base >= 2) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL reset_mid_setup: got %0d starts, need 2", starts_a - base);
    end
    rst = 1'b1;
    auto_a = 1'b0; cnt_a = 0; ifa.i_tx_done = 1'b0;
    q_a.delete();
    #1;
    n_tests++;
    if ({ifa.o_tx_data, ifa.o_tx_start, ifa.o_word_ready, ifa.o_busy, ifa.o_overflow}
        !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got data=%02h start=%b ready=%b busy=%b ovf=%b, need 00 0 1 0 0",
               ifa.o_tx_data, ifa.o_tx_start, ifa.o_word_ready, ifa.o_busy, ifa.o_overflow);
    end
    tick();
    rst = 1'b0;
    base = starts_a;
    repeat (100) tick();
    n_tests++;
    if (starts_a != base || ifa.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got %0d starts busy=%b, need 0 starts busy=0",
               starts_a - base, ifa.o_busy);
    end
  endtask

  task automatic test_debug_stream();
    int base;
    int idx;
    logic [31:0] w;
    do_reset();
    gap = 3; auto_a = 1'b1;
    base = starts_a;
    idx = 0;
    for (int c = 0; c < 5000 && idx < 33; c++) begin
      if (ifa.o_word_ready) begin
        w = (idx == 32) ? 32'hFFFFFFFF : (32'h01010101 * idx + 32'h80402010);
        push_a(w, 1'b1);
        idx++;
      end else begin
        tick();
      end
    end
    wait_drain(3000, "debug_stream");
    n_tests++;
    if (idx != 33 || starts_a - base != 132 || ifa.o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL debug_stream: got %0d words %0d bytes ovf=%b, need 33 132 ovf=0",
               idx, starts_a - base, ifa.o_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_word();
    test_debug_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
